// File: rtl/reg_dump_unit_pkg.sv
// Shared definitions for the register dump unit: FSM state encoding,
// the stream header byte and the bytes-per-register derivation.
// Optional feature macro: REG_DUMP_HEADER_EN adds the HEADER state.
package reg_dump_unit_pkg;

    localparam int         NBITS_DEFAULT = 32;
    localparam int         BYTES_PER_REG = NBITS_DEFAULT / 8;
    localparam logic [7:0] HEADER_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_SEND,
        ST_DONE
`ifdef REG_DUMP_HEADER_EN
        ,
        ST_HEADER
`endif
    } state_t;

    // Number of bytes a register of the given width occupies on the stream.
    function automatic int bytes_per_reg(input int nbits);
        return nbits / 8;
    endfunction

endpackage

// File: rtl/reg_dump_unit_byte_serializer.sv
// Load/shift register that offers its contents one byte at a time,
// MSB first, under a valid/ready handshake. o_last flags the cycle in
// which the final byte (index i_last_idx) is accepted.
module byte_serializer #(
    parameter int NBITS = 32,
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [NBITS-1:0] i_data,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last_idx,
    input  logic             i_tx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next shift-register/counter contents: load wins, otherwise shift on handshake.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        o_last  = 1'b0;
        if (i_load) begin
            shreg_d = i_data;
            cnt_d   = '0;
        end else if (i_en && i_tx_ready) begin
            shreg_d = shreg_q << 8;
            if (cnt_q == i_last_idx) begin
                o_last = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_tx_data  = shreg_q[NBITS-1 -: 8];
    assign o_tx_valid = i_en;

endmodule

// File: rtl/reg_dump_unit.sv
// Register dump unit: walks register addresses 0..TAM-1, reads each one
// through the debug port and streams it out MSB first, then pulses
// o_done. In IDLE it can also issue a single-cycle processor step.
// Optional feature macro: REG_DUMP_HEADER_EN prefixes the stream with 0xA5.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int REGS  = 5,
    parameter int NBITS = NBITS_DEFAULT,
    parameter int TAM   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_step_req,
    output logic [REGS-1:0]  o_reg_addr,
    input  logic [NBITS-1:0] i_reg_data,
    output logic             o_step,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_done
);

    localparam int              BYTES     = bytes_per_reg(NBITS);
    localparam int              CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [REGS-1:0] LAST_ADDR = REGS'(TAM - 1);
    localparam logic [REGS-1:0] ADDR_ONE  = REGS'(1);

    state_t          state_q, state_d;
    logic [REGS-1:0] addr_q, addr_d;
    logic            step_q, step_d;

    logic             ser_load;
    logic [NBITS-1:0] ser_data;
    logic             ser_en;
    logic [CNT_W-1:0] ser_last_idx;
    logic             ser_last;

    byte_serializer #(
        .NBITS (NBITS),
        .CNT_W (CNT_W)
    ) u_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_data     (ser_data),
        .i_en       (ser_en),
        .i_last_idx (ser_last_idx),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_last     (ser_last)
    );

    // Next-state, address and step logic plus serializer control.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        step_d       = 1'b0;
        ser_load     = 1'b0;
        ser_data     = i_reg_data;
        ser_en       = 1'b0;
        ser_last_idx = CNT_W'(BYTES - 1);
        o_done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d = '0;
`ifdef REG_DUMP_HEADER_EN
                    // Header goes through the serializer as a one-byte word.
                    ser_load = 1'b1;
                    ser_data = NBITS'(HEADER_BYTE) << (NBITS - 8);
                    state_d  = ST_HEADER;
`else
                    state_d  = ST_ADDR;
`endif
                end else if (i_step_req) begin
                    step_d = 1'b1;
                end
            end
`ifdef REG_DUMP_HEADER_EN
            ST_HEADER: begin
                ser_en       = 1'b1;
                ser_last_idx = '0;
                if (ser_last) begin
                    state_d = ST_ADDR;
                end
            end
`endif
            ST_ADDR: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                ser_en = 1'b1;
                if (ser_last) begin
                    if (addr_q < LAST_ADDR) begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // FSM, address and step registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            step_q  <= step_d;
        end
    end

    assign o_reg_addr = addr_q;
    assign o_step     = step_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed testbench for reg_dump_unit. The register file model returns
// the address as data. Inputs are driven and outputs sampled on the
// falling edge, half a cycle away from the active rising edge.
module tb_reg_dump_unit;

    localparam int REGS  = 5;
    localparam int NBITS = 32;
    localparam int TAM   = 32;
`ifdef REG_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NBYTES    = HDR + TAM * 4;
    localparam int FIRST_K   = HDR ? 0 : 2;
    localparam int DONE_K    = 192 + HDR;
    localparam int STALL_IDX = HDR + 11;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_start;
    logic             i_step_req;
    logic [REGS-1:0]  o_reg_addr;
    logic [NBITS-1:0] i_reg_data;
    logic             o_step;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;
    logic             i_tx_ready;
    logic             o_busy;
    logic             o_done;

    int checks = 0;
    int errors = 0;

    reg_dump_unit #(
        .REGS  (REGS),
        .NBITS (NBITS),
        .TAM   (TAM)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_step_req (i_step_req),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (i_reg_data),
        .o_step     (o_step),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    assign i_reg_data = {{(NBITS-REGS){1'b0}}, o_reg_addr};

    function automatic logic [7:0] exp_byte(input int j);
        int jj;
        if (HDR == 1 && j == 0) return 8'hA5;
        jj = j - HDR;
        if (jj % 4 == 3) return 8'(jj / 4);
        return 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] got[$];
        int first_k, done_k, done_cnt, step_hi, stall, nacc;

        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_step_req = 1'b0;
        i_tx_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_addr",  32'(o_reg_addr), 32'd0);
        check("rst_valid", 32'(o_tx_valid), 32'd0);
        check("rst_data",  32'(o_tx_data),  32'd0);
        check("rst_step",  32'(o_step),     32'd0);
        check("rst_busy",  32'(o_busy),     32'd0);
        check("rst_done",  32'(o_done),     32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Single step from IDLE
        i_step_req = 1'b1;
        @(negedge i_clk);
        i_step_req = 1'b0;
        check("step_hi",   32'(o_step), 32'd1);
        check("step_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        check("step_lo", 32'(o_step), 32'd0);
        $display("step pulse: o_step one cycle");

        // Full dump, ready always high, step request mid-dump
        got.delete();
        first_k = -1; done_k = -1; done_cnt = 0; step_hi = 0;
        i_start = 1'b1;
        for (int k = 0; k < 220; k++) begin
            @(negedge i_clk);
            if (k == 0) i_start = 1'b0;
            i_step_req = (k == 50);
            if (o_tx_valid) begin
                if (first_k < 0) first_k = k;
                got.push_back(o_tx_data);
            end
            if (o_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (o_step) step_hi++;
        end
        check("dump_first_valid", 32'(first_k), 32'(FIRST_K));
        check("dump_nbytes", 32'(got.size()), 32'(NBYTES));
        for (int j = 0; j < got.size() && j < NBYTES; j++)
            check($sformatf("dump_byte%0d", j), 32'(got[j]), 32'(exp_byte(j)));
        check("dump_done_cnt", 32'(done_cnt), 32'd1);
        check("dump_done_k",   32'(done_k),   32'(DONE_K));
        check("dump_no_step",  32'(step_hi),  32'd0);
        check("dump_idle",     32'(o_busy),   32'd0);
        $display("dump: %0d bytes, done at cycle %0d", got.size(), done_k);

        // Back-pressure on register 2 byte 3
        got.delete();
        done_cnt = 0; stall = 0;
        i_start = 1'b1;
        for (int k = 0; k < 240; k++) begin
            @(negedge i_clk);
            if (k == 0) i_start = 1'b0;
            if (o_tx_valid && got.size() == STALL_IDX && stall < 3) begin
                i_tx_ready = 1'b0;
                stall++;
                check("stall_data",  32'(o_tx_data),  32'h02);
                check("stall_valid", 32'(o_tx_valid), 32'd1);
            end else begin
                i_tx_ready = 1'b1;
            end
            if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
            if (o_done) done_cnt++;
        end
        i_tx_ready = 1'b1;
        check("bp_stalls", 32'(stall), 32'd3);
        check("bp_nbytes", 32'(got.size()), 32'(NBYTES));
        for (int j = 0; j < got.size() && j < NBYTES; j++)
            check($sformatf("bp_byte%0d", j), 32'(got[j]), 32'(exp_byte(j)));
        check("bp_done_cnt", 32'(done_cnt), 32'd1);
        $display("backpressure: %0d stall cycles, %0d bytes", stall, got.size());

        // Start and step together, then reset after 10 bytes
        i_start    = 1'b1;
        i_step_req = 1'b1;
        @(negedge i_clk);
        i_start    = 1'b0;
        i_step_req = 1'b0;
        check("both_busy", 32'(o_busy), 32'd1);
        check("both_step", 32'(o_step), 32'd0);
        nacc = 0; step_hi = 0;
        for (int k = 0; k < 60 && nacc < 10; k++) begin
            @(negedge i_clk);
            if (o_step) step_hi++;
            if (o_tx_valid && i_tx_ready) nacc++;
        end
        check("both_nacc",    32'(nacc),    32'd10);
        check("both_no_step", 32'(step_hi), 32'd0);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check("mid_rst_valid", 32'(o_tx_valid), 32'd0);
        check("mid_rst_busy",  32'(o_busy),     32'd0);
        check("mid_rst_addr",  32'(o_reg_addr), 32'd0);
        check("mid_rst_data",  32'(o_tx_data),  32'd0);
        $display("reset after %0d bytes: stream abandoned", nacc);

        // Restart: stream begins again from register 0
        got.delete();
        i_start = 1'b1;
        for (int k = 0; k < 30 && got.size() < 4; k++) begin
            @(negedge i_clk);
            if (k == 0) i_start = 1'b0;
            if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
        end
        check("restart_nbytes", 32'(got.size()), 32'd4);
        for (int j = 0; j < got.size() && j < 4; j++)
            check($sformatf("restart_byte%0d", j), 32'(got[j]), 32'(exp_byte(j)));
        $display("restart: first %0d bytes captured", got.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
